// File: rtl/reg_bus_arbiter.sv
// Two-requester (SPI command path / control core) arbiter for the internal register bus.
// Round-robin grant, req/ack bus handshake with timeout, and SPI abort suppression of the response.
module reg_bus_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_spi_req,
    input  logic              i_spi_write,
    input  logic [ADDR_W-1:0] i_spi_addr,
    input  logic [DATA_W-1:0] i_spi_wdata,
    input  logic              i_spi_abort,
    output logic              o_spi_ack,
    output logic [DATA_W-1:0] o_spi_rdata,
    output logic              o_spi_err,
    input  logic              i_core_req,
    input  logic              i_core_write,
    input  logic [ADDR_W-1:0] i_core_addr,
    input  logic [DATA_W-1:0] i_core_wdata,
    output logic              o_core_ack,
    output logic [DATA_W-1:0] o_core_rdata,
    output logic              o_core_err,
    output logic              o_bus_req,
    output logic              o_bus_write,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_wdata,
    input  logic              i_bus_ack,
    input  logic [DATA_W-1:0] i_bus_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic GNT_SPI  = 1'b0;
    localparam logic GNT_CORE = 1'b1;

    // Counter only has to reach TIMEOUT-1; the following BUSY cycle is the timeout.
    localparam int              CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic             last_grant;
    logic             gnt;
    logic             abort_flag;

    logic             spi_eff;
    logic             pick_core;
    logic             timeout_hit;
    logic             spi_deliver;
    logic [DATA_W-1:0] resp_rdata;

    assign spi_eff     = i_spi_req & ~i_spi_abort;
    assign pick_core   = i_core_req & (~spi_eff | (last_grant == GNT_SPI));
    assign timeout_hit = (cnt == CNT_LAST);
    assign spi_deliver = ~(abort_flag | i_spi_abort);
    // Writes and timeouts return zero; only an acked read carries slave data.
    assign resp_rdata  = (i_bus_ack && !o_bus_write) ? i_bus_rdata : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            last_grant   <= GNT_CORE;
            gnt          <= GNT_SPI;
            abort_flag   <= 1'b0;
            o_spi_ack    <= 1'b0;
            o_spi_rdata  <= '0;
            o_spi_err    <= 1'b0;
            o_core_ack   <= 1'b0;
            o_core_rdata <= '0;
            o_core_err   <= 1'b0;
            o_bus_req    <= 1'b0;
            o_bus_write  <= 1'b0;
            o_bus_addr   <= '0;
            o_bus_wdata  <= '0;
        end else begin
            o_spi_ack  <= 1'b0;
            o_core_ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    abort_flag <= 1'b0;
                    if (spi_eff || i_core_req) begin
                        gnt         <= pick_core;
                        last_grant  <= pick_core;
                        o_bus_req   <= 1'b1;
                        o_bus_write <= pick_core ? i_core_write : i_spi_write;
                        o_bus_addr  <= pick_core ? i_core_addr  : i_spi_addr;
                        o_bus_wdata <= pick_core ? i_core_wdata : i_spi_wdata;
                        cnt         <= '0;
                        state       <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (gnt == GNT_SPI && i_spi_abort) begin
                        abort_flag <= 1'b1;
                    end
                    // Ack is checked first so it wins over a coincident timeout.
                    if (i_bus_ack || timeout_hit) begin
                        o_bus_req <= 1'b0;
                        state     <= S_RESP;
                        if (gnt == GNT_CORE) begin
                            o_core_ack   <= 1'b1;
                            o_core_rdata <= resp_rdata;
                            o_core_err   <= ~i_bus_ack;
                        end else if (spi_deliver) begin
                            o_spi_ack   <= 1'b1;
                            o_spi_rdata <= resp_rdata;
                            o_spi_err   <= ~i_bus_ack;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Scoreboard bench for reg_bus_arbiter: expected bus grants and responses are queued
// when stimulus is driven and compared when the DUT raises o_bus_req or an ack.
module tb_reg_bus_arbiter;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_spi_req, i_spi_write, i_spi_abort;
    logic [ADDR_W-1:0] i_spi_addr;
    logic [DATA_W-1:0] i_spi_wdata;
    logic              o_spi_ack, o_spi_err;
    logic [DATA_W-1:0] o_spi_rdata;
    logic              i_core_req, i_core_write;
    logic [ADDR_W-1:0] i_core_addr;
    logic [DATA_W-1:0] i_core_wdata;
    logic              o_core_ack, o_core_err;
    logic [DATA_W-1:0] o_core_rdata;
    logic              o_bus_req, o_bus_write;
    logic [ADDR_W-1:0] o_bus_addr;
    logic [DATA_W-1:0] o_bus_wdata;
    logic              i_bus_ack;
    logic [DATA_W-1:0] i_bus_rdata;

    logic              slave_ack = 1'b0;
    logic              late_ack  = 1'b0;
    int                slave_delay = 0;
    logic [DATA_W-1:0] slave_rdata = '0;

    int checks = 0;
    int errors = 0;

    logic [16:0] spi_q[$];
    logic [16:0] core_q[$];
    logic [24:0] bus_q[$];
    int          last_hi_len = 0;

    assign i_bus_ack = slave_ack | late_ack;

    always #5 clk = ~clk;

    reg_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_spi_req(i_spi_req), .i_spi_write(i_spi_write), .i_spi_addr(i_spi_addr),
        .i_spi_wdata(i_spi_wdata), .i_spi_abort(i_spi_abort),
        .o_spi_ack(o_spi_ack), .o_spi_rdata(o_spi_rdata), .o_spi_err(o_spi_err),
        .i_core_req(i_core_req), .i_core_write(i_core_write), .i_core_addr(i_core_addr),
        .i_core_wdata(i_core_wdata),
        .o_core_ack(o_core_ack), .o_core_rdata(o_core_rdata), .o_core_err(o_core_err),
        .o_bus_req(o_bus_req), .o_bus_write(o_bus_write), .o_bus_addr(o_bus_addr),
        .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_rdata(i_bus_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic any_output();
        return |{o_spi_ack, o_spi_rdata, o_spi_err, o_core_ack, o_core_rdata, o_core_err,
                 o_bus_req, o_bus_write, o_bus_addr, o_bus_wdata};
    endfunction

    // Slave: acks slave_delay cycles after o_bus_req rises; negative delay never acks.
    initial begin
        int  wcnt;
        bit  acked;
        wcnt  = 0;
        acked = 0;
        i_bus_rdata = 16'hDEAD;
        forever begin
            @(negedge clk);
            slave_ack = 1'b0;
            if (o_bus_req && !acked && slave_delay >= 0) begin
                if (wcnt == slave_delay) begin
                    slave_ack = 1'b1;
                    acked     = 1;
                end else begin
                    wcnt++;
                end
            end else if (!o_bus_req) begin
                wcnt  = 0;
                acked = 0;
            end
            i_bus_rdata = slave_ack ? slave_rdata : 16'hDEAD;
        end
    end

    // Monitor: grant fields on o_bus_req rise, field stability while high, responses on acks.
    initial begin
        logic        prev_req;
        logic [24:0] held;
        int          hi_len;
        prev_req = 1'b0;
        held     = '0;
        hi_len   = 0;
        forever begin
            @(negedge clk);
            if (o_bus_req && !prev_req) begin
                hi_len = 1;
                held   = {o_bus_write, o_bus_addr, o_bus_wdata};
                if (bus_q.size() == 0) check("bus_unexpected_grant", 1, 0);
                else check("bus_grant_fields", held, bus_q.pop_front());
            end else if (o_bus_req) begin
                hi_len++;
                check("bus_fields_stable", {o_bus_write, o_bus_addr, o_bus_wdata}, held);
            end
            if (!o_bus_req && prev_req) last_hi_len = hi_len;
            prev_req = o_bus_req;
            if (o_spi_ack) begin
                if (spi_q.size() == 0) check("spi_unexpected_ack", 1, 0);
                else check("spi_resp", {o_spi_err, o_spi_rdata}, spi_q.pop_front());
            end
            if (o_core_ack) begin
                if (core_q.size() == 0) check("core_unexpected_ack", 1, 0);
                else check("core_resp", {o_core_err, o_core_rdata}, core_q.pop_front());
            end
        end
    end

    // Drives one request (called on a negedge), holds it until the ack, drops it after.
    task automatic do_txn(input bit is_core, input bit wr, input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d, input int exp_lat, input bit scramble);
        int n;
        bit got;
        n   = 0;
        got = 0;
        if (is_core) begin
            i_core_req = 1'b1; i_core_write = wr; i_core_addr = a; i_core_wdata = d;
        end else begin
            i_spi_req = 1'b1; i_spi_write = wr; i_spi_addr = a; i_spi_wdata = d;
        end
        while (!got && n < 200) begin
            @(negedge clk);
            n++;
            if (scramble) begin
                i_spi_write = ~wr; i_spi_addr = ~a; i_spi_wdata = ~d;
            end
            got = is_core ? o_core_ack : o_spi_ack;
        end
        check(is_core ? "core_ack_seen" : "spi_ack_seen", 32'(got), 1);
        if (exp_lat >= 0) check(is_core ? "core_ack_latency" : "spi_ack_latency", n, exp_lat);
        if (is_core) i_core_req = 1'b0;
        else i_spi_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1;
        i_spi_req = 0; i_spi_write = 0; i_spi_addr = '0; i_spi_wdata = '0; i_spi_abort = 0;
        i_core_req = 0; i_core_write = 0; i_core_addr = '0; i_core_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs_zero", 32'(any_output()), 0);
        i_rst = 1'b0;
        @(negedge clk);

        // Contention straight out of reset: SPI, CORE, SPI, CORE
        slave_delay = 1; slave_rdata = 16'h0F0F;
        bus_q.push_back({1'b1, 8'hA0, 16'h1111});
        bus_q.push_back({1'b0, 8'hB0, 16'h0000});
        bus_q.push_back({1'b0, 8'hA1, 16'h0000});
        bus_q.push_back({1'b1, 8'hB1, 16'h2222});
        spi_q.push_back({1'b0, 16'h0000});
        spi_q.push_back({1'b0, 16'h0F0F});
        core_q.push_back({1'b0, 16'h0F0F});
        core_q.push_back({1'b0, 16'h0000});
        fork
            begin
                do_txn(0, 1, 8'hA0, 16'h1111, -1, 0);
                do_txn(0, 0, 8'hA1, 16'h0000, -1, 0);
            end
            begin
                do_txn(1, 0, 8'hB0, 16'h0000, -1, 0);
                do_txn(1, 1, 8'hB1, 16'h2222, -1, 0);
            end
        join
        @(negedge clk);

        // SPI write, slave acks 3 cycles after o_bus_req; fields change after grant
        slave_delay = 3; slave_rdata = 16'h7777;
        bus_q.push_back({1'b1, 8'h12, 16'hBEEF});
        spi_q.push_back({1'b0, 16'h0000});
        do_txn(0, 1, 8'h12, 16'hBEEF, 5, 1);
        check("core_untouched", {o_core_err, o_core_rdata}, {1'b0, 16'h0000});
        @(negedge clk);

        // Core read, zero-wait slave
        slave_delay = 0; slave_rdata = 16'h1234;
        bus_q.push_back({1'b0, 8'h05, 16'h0000});
        core_q.push_back({1'b0, 16'h1234});
        do_txn(1, 0, 8'h05, 16'h0000, 2, 0);
        @(negedge clk);

        // Ack in the same cycle the timeout would fire: ack wins
        slave_delay = TIMEOUT - 1; slave_rdata = 16'h5A5A;
        bus_q.push_back({1'b0, 8'h40, 16'h0000});
        spi_q.push_back({1'b0, 16'h5A5A});
        do_txn(0, 0, 8'h40, 16'h0000, TIMEOUT + 1, 0);
        @(negedge clk);
        check("ack_at_limit_req_len", last_hi_len, TIMEOUT);

        // Non-acking slave: timeout error, then a stray ack in IDLE is ignored
        slave_delay = -1;
        bus_q.push_back({1'b0, 8'h41, 16'h0000});
        spi_q.push_back({1'b1, 16'h0000});
        do_txn(0, 0, 8'h41, 16'h0000, TIMEOUT + 1, 0);
        @(negedge clk);
        check("timeout_req_len", last_hi_len, TIMEOUT);
        late_ack = 1'b1;
        @(negedge clk);
        late_ack = 1'b0;
        @(negedge clk);
        check("late_ack_ignored", {o_bus_req, o_spi_err, o_spi_rdata}, {1'b0, 1'b1, 16'h0000});

        // Establish an old SPI read value, then abort an SPI read with core pending
        slave_delay = 0; slave_rdata = 16'hC3C3;
        bus_q.push_back({1'b0, 8'h50, 16'h0000});
        spi_q.push_back({1'b0, 16'hC3C3});
        do_txn(0, 0, 8'h50, 16'h0000, 2, 0);
        @(negedge clk);
        slave_delay = 3; slave_rdata = 16'hAAAA;
        bus_q.push_back({1'b0, 8'h30, 16'h0000});
        bus_q.push_back({1'b0, 8'h31, 16'h0000});
        core_q.push_back({1'b0, 16'hAAAA});
        i_spi_req = 1'b1; i_spi_write = 1'b0; i_spi_addr = 8'h30;
        @(negedge clk);
        i_core_req = 1'b1; i_core_write = 1'b0; i_core_addr = 8'h31;
        i_spi_abort = 1'b1;
        @(negedge clk);
        i_spi_abort = 1'b0;
        i_spi_req   = 1'b0;
        do_txn(1, 0, 8'h31, 16'h0000, -1, 0);
        check("abort_spi_hold", {o_spi_err, o_spi_rdata}, {1'b0, 16'hC3C3});
        @(negedge clk);

        // Reset two cycles into a core transaction
        slave_delay = -1;
        bus_q.push_back({1'b0, 8'h60, 16'h0000});
        i_core_req = 1'b1; i_core_write = 1'b0; i_core_addr = 8'h60;
        repeat (2) @(negedge clk);
        i_rst = 1'b1;
        @(negedge clk);
        check("midtxn_reset_zero", 32'(any_output()), 0);
        i_rst = 1'b0;
        i_core_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests after reset: SPI first
        slave_delay = 0; slave_rdata = 16'h1111;
        bus_q.push_back({1'b0, 8'h70, 16'h0000});
        bus_q.push_back({1'b0, 8'h71, 16'h0000});
        spi_q.push_back({1'b0, 16'h1111});
        core_q.push_back({1'b0, 16'h1111});
        fork
            do_txn(0, 0, 8'h70, 16'h0000, 2, 0);
            do_txn(1, 0, 8'h71, 16'h0000, -1, 0);
        join
        repeat (3) @(negedge clk);

        check("scoreboard_drained", spi_q.size() + core_q.size() + bus_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
